// File: rtl/vga_scan_if.sv
// Pixel-path bundle between the raster timing generator (master) and the
// cell renderer / VGA pins (slave).
interface vga_scan_if;
    logic        pix_ce;
    logic [11:0] rgb_in;
    logic [10:0] x;
    logic [10:0] y;
    logic [11:0] vga_rgb;
    logic        vga_hs;
    logic        vga_vs;
    logic        frame_tick;

    modport master (
        input  pix_ce, rgb_in,
        output x, y, vga_rgb, vga_hs, vga_vs, frame_tick
    );

    modport slave (
        output pix_ce, rgb_in,
        input  x, y, vga_rgb, vga_hs, vga_vs, frame_tick
    );
endinterface

// File: rtl/vga_scan.sv
// Raster timing generator and registered VGA output stage with a per-frame tick.
// Build option: VGA_SYNC_ACTIVE_HIGH_EN selects active-high sync (default build: active-low).
module vga_scan #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 48,
    parameter int unsigned H_SYNC   = 112,
    parameter int unsigned H_BP     = 248,
    parameter int unsigned V_ACTIVE = 1024,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 3,
    parameter int unsigned V_BP     = 38
) (
    input  logic      clk,
    input  logic      rst_n,
    vga_scan_if.master bus
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_size_check
            $error("vga_scan: H_TOTAL and V_TOTAL must not exceed 2048");
        end
    endgenerate

`ifdef VGA_SYNC_ACTIVE_HIGH_EN
    localparam logic SYNC_ON = 1'b1;
`else
    localparam logic SYNC_ON = 1'b0;
`endif
    localparam logic SYNC_OFF = ~SYNC_ON;

    // 12-bit compare constants so a boundary of exactly 2048 does not wrap.
    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_VIS_END  = 12'(H_ACTIVE);
    localparam logic [11:0] V_VIS_END  = 12'(V_ACTIVE);
    localparam logic [11:0] HS_START   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END     = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_START   = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END     = 12'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic [11:0] rgb_q, rgb_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        tick_q, tick_d;

    logic [11:0] x_ext;
    logic [11:0] y_ext;
    logic        visible;
    logic        hs_on;
    logic        vs_on;

    assign x_ext   = {1'b0, x_q};
    assign y_ext   = {1'b0, y_q};
    assign visible = (x_ext < H_VIS_END) && (y_ext < V_VIS_END);
    assign hs_on   = (x_ext >= HS_START) && (x_ext < HS_END);
    assign vs_on   = (y_ext >= VS_START) && (y_ext < VS_END);

    always_comb begin
        // NOTE: every signal gets a hold/default value first so no path leaves it unassigned (no latch).
        x_d    = x_q;
        y_d    = y_q;
        rgb_d  = rgb_q;
        hs_d   = hs_q;
        vs_d   = vs_q;
        tick_d = 1'b0;
        if (bus.pix_ce) begin
            if (x_ext == H_LAST) begin
                x_d = '0;
                y_d = (y_ext == V_LAST) ? '0 : y_q + 11'd1;
            end else begin
                x_d = x_q + 11'd1;
            end
            // Outputs describe the coordinate presented during this cycle.
            rgb_d  = visible ? bus.rgb_in : 12'h000;
            hs_d   = hs_on ? SYNC_ON : SYNC_OFF;
            vs_d   = vs_on ? SYNC_ON : SYNC_OFF;
            tick_d = (x_q == 11'd0) && (y_ext == V_VIS_END);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            rgb_q  <= 12'h000;
            hs_q   <= SYNC_OFF;
            vs_q   <= SYNC_OFF;
            tick_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            rgb_q  <= rgb_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            tick_q <= tick_d;
        end
    end

    assign bus.x          = x_q;
    assign bus.y          = y_q;
    assign bus.vga_rgb    = rgb_q;
    assign bus.vga_hs     = hs_q;
    assign bus.vga_vs     = vs_q;
    assign bus.frame_tick = tick_q;

endmodule

// File: doc/vga_scan.md
# vga_scan

Raster timing generator and pixel output stage for the Game of Life VGA path. It sweeps the pixel coordinates `x`/`y` that drive the cell renderer and samples the renderer's combinational colour return. It then drives the registered VGA pins with sync and blanking aligned to that colour. It also emits a once-per-frame tick at the start of vertical blanking, which the life engine uses to advance a generation without tearing.

## Interface
Parameters (defaults give 1280x1024@60, 108 MHz pixel rate):
- `H_ACTIVE`, 1280, visible pixels per line
- `H_FP`, 48, horizontal front porch
- `H_SYNC`, 112, horizontal sync width
- `H_BP`, 248, horizontal back porch (H_TOTAL = 1688)
- `V_ACTIVE`, 1024, visible lines
- `V_FP`, 1, vertical front porch
- `V_SYNC`, 3, vertical sync width
- `V_BP`, 38, vertical back porch (V_TOTAL = 1066)

Ports:
- `clk` input 1: pixel-domain clock
- `rst_n` input 1: asynchronous, active-low reset
- `pix_ce` input 1: pixel clock enable; all state advances only when high
- `rgb_in` input 12: colour from the renderer for the current `x`/`y`
- `x` output 11: current horizontal count, 0..H_TOTAL-1
- `y` output 11: current vertical count, 0..V_TOTAL-1
- `vga_rgb` output 12: registered pixel colour, {R[3:0],G[3:0],B[3:0]}
- `vga_hs` output 1: registered horizontal sync
- `vga_vs` output 1: registered vertical sync
- `frame_tick` output 1: one-`pix_ce`-cycle pulse at the first blanked line

## Operation
- `x` and `y` are the counter registers themselves. They are never combinational from other state.
- On each `pix_ce`:
  - `x` increments.
  - At `x == H_TOTAL-1`, `x` becomes 0 and `y` increments.
  - At `x == H_TOTAL-1` and `y == V_TOTAL-1`, both become 0.
- Visible region: `x < H_ACTIVE` and `y < V_ACTIVE`.
- hsync is active for `H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC`.
- vsync is active for `V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC`. vsync is line-based and ignores `x`.
- `vga_rgb` is registered as `rgb_in` when visible, else 12'h000. Colour is never passed through during blanking, whatever the renderer returns.
- `frame_tick` is registered as (`x == 0` and `y == V_ACTIVE`).
- Counter widths are fixed at 11 bits. H_TOTAL and V_TOTAL must each be at most 2048, and this is checked by a synthesis-time assertion.
- When `pix_ce` is low:
  - counters hold;
  - `vga_*` hold their last values;
  - `frame_tick` drops to 0 (it is a pulse).

## Timing
- Reset (async assert, sync release on `clk`):
  - `x` = 0, `y` = 0;
  - `vga_rgb` = 0;
  - `vga_hs` and `vga_vs` at their inactive level;
  - `frame_tick` = 0.
- Latency: `x`/`y` at enable edge N are presented, the renderer responds combinationally within that cycle, and `vga_rgb`/`vga_hs`/`vga_vs` reflect that same coordinate after edge N+1. This is exactly 1 `pix_ce` cycle, so sync and colour stay mutually aligned.
- First `pix_ce` after reset release:
  - outputs show coordinate (0,0);
  - counters move to (1,0).
- `frame_tick` is high for exactly one `pix_ce` cycle per frame, one cycle after (0,V_ACTIVE) is presented. The life engine has the whole of blanking (V_TOTAL-V_ACTIVE lines) to update.
- Reset asserted mid-line or mid-sync: outputs go to the reset values immediately, with no partial sync pulse extension. Scanning restarts at (0,0).

## Configuration
- `VGA_SYNC_ACTIVE_HIGH_EN`:
  - Defined: `vga_hs`/`vga_vs` are 1 during sync and 0 otherwise. This is required for the default 1280x1024 mode, and the reset level is 0.
  - Undefined: both syncs are active-low (1 idle, 0 during sync, reset level 1) for 640x480-style modes.
  - Blanking and colour behaviour are identical in both builds.

## Test plan
- Reset then 1688 `pix_ce` cycles with `pix_ce` held high: `x` runs 0..1687, returns to 0, and `y` becomes 1.
- Drive `rgb_in` = 12'hF0F constant: `vga_rgb` = F0F for 1280 cycles per visible line, 000 for 408, and 000 on all of lines 1024..1065.
- Full frame with the macro defined: `vga_hs` high for exactly 112 cycles starting at presented `x` = 1328. `vga_vs` high on lines 1025..1027 only. The frame repeats every 1688*1066 = 1,799,408 cycles.
- Toggle `pix_ce` 1-in-4: counts and outputs advance only on enabled edges. `frame_tick` is 1 for a single enabled cycle per frame.
- Assert `rst_n` low at `x` = 1400, `y` = 1026 (inside sync): outputs reset immediately. After release, `x`/`y` restart from 0 and the next `frame_tick` comes 1024 lines later.
- Build without the macro: sync levels are inverted and reset leaves `vga_hs` = `vga_vs` = 1. Colour timing is unchanged.
